// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register addresses, field positions, exception codes
// and the handler entry point used by the next-PC logic.
package cp0_defs;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int IP_LO   = 10;
  localparam int EXC_LO  = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_ENTRY = 32'h0000_4180;

endpackage

// File: rtl/cp0_regfile_int_arb.sv
// Interrupt/exception arbiter: decides whether to trap this cycle and which
// ExcCode gets recorded. Interrupts take precedence over synchronous faults.
module cp0_int_arb
  import cp0_defs::*;
#(
  parameter int HW_INT_W = 6
) (
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic [HW_INT_W-1:0] im,
  input  logic                ie,
  input  logic                exl,
  input  logic [4:0]          exc_code_in,
  output logic                int_req,
  output logic                exc_req,
  output logic                req,
  output logic [4:0]          exc_code
);

  assign int_req  = (|(hw_int & im)) & ie & ~exl;
  assign exc_req  = (exc_code_in != 5'd0) & ~exl;
  assign req      = int_req | exc_req;
  assign exc_code = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file (SR, Cause, EPC, PRId) at the M stage; raises Req
// to redirect fetch to the handler and supplies EPC for eret.
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2021_0C07,
  parameter int          HW_INT_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          A1,
  input  logic [4:0]          A2,
  input  logic [31:0]         DIn,
  input  logic                WE,
  input  logic [31:0]         VPC,
  input  logic                BDIn,
  input  logic [4:0]          ExcCodeIn,
  input  logic [HW_INT_W-1:0] HWInt,
  input  logic                EXLClr,
  output logic [31:0]         DOut,
  output logic [31:0]         EPCOut,
  output logic                Req
);

  logic [HW_INT_W-1:0] sr_im;
  logic                sr_exl;
  logic                sr_ie;
  logic                cause_bd;
  logic [HW_INT_W-1:0] cause_ip;
  logic [4:0]          cause_exc;
  logic [31:0]         epc;

  logic                int_req;
  logic                exc_req;
  logic [4:0]          exc_sel;
  logic [31:0]         vpc_aligned;
  logic [31:0]         epc_victim;
  logic                wr_sr;
  logic                wr_epc;

  cp0_int_arb #(.HW_INT_W(HW_INT_W)) u_arb (
    .hw_int      (HWInt),
    .im          (sr_im),
    .ie          (sr_ie),
    .exl         (sr_exl),
    .exc_code_in (ExcCodeIn),
    .int_req     (int_req),
    .exc_req     (exc_req),
    .req         (Req),
    .exc_code    (exc_sel)
  );

  // A delay-slot victim restarts at the branch so the branch is re-executed.
  assign vpc_aligned = VPC & 32'hFFFF_FFFC;
  assign epc_victim  = BDIn ? vpc_aligned - 32'd4 : vpc_aligned;
  assign wr_sr       = WE & ~Req & (A2 == ADDR_SR);
  assign wr_epc      = WE & ~Req & (A2 == ADDR_EPC);
  assign EPCOut      = wr_epc ? DIn : epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= HWInt;
      if (Req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= BDIn;
        cause_exc <= exc_sel;
        epc       <= epc_victim;
      end else begin
        if (wr_sr) begin
          sr_im  <= DIn[IM_LO +: HW_INT_W];
          sr_exl <= DIn[EXL_BIT];
          sr_ie  <= DIn[IE_BIT];
        end
        // NOTE: the last non-blocking assignment wins, so eret beats an mtc0 SR.EXL=1.
        if (EXLClr) sr_exl <= 1'b0;
        if (wr_epc) epc <= DIn;
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns DOut and no latch is inferred.
    DOut = '0;
    case (A1)
      ADDR_SR: begin
        DOut[IM_LO +: HW_INT_W] = sr_im;
        DOut[EXL_BIT]           = sr_exl;
        DOut[IE_BIT]            = sr_ie;
      end
      ADDR_CAUSE: begin
        DOut[BD_BIT]            = cause_bd;
        DOut[IP_LO +: HW_INT_W] = cause_ip;
        DOut[EXC_LO +: 5]       = cause_exc;
      end
      ADDR_EPC:  DOut = epc;
      ADDR_PRID: DOut = PRID_VALUE;
      default:   DOut = '0;
    endcase
  end

endmodule
